// File: rtl/dijkstra_pkg.sv
// Shared definitions for the Dijkstra custom-instruction datapath.
// Holds the IEEE-754 +inf constant, the command encoding and a NaN test.
package dijkstra_pkg;

   localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {
      CMD_CLEAR     = 2'd0,
      CMD_PUSH      = 2'd1,
      CMD_READ_IDX  = 2'd2,
      CMD_READ_DIST = 2'd3
   } cmd_e;

   // Single-precision NaN: all-ones exponent with a non-zero mantissa.
   function automatic logic fp_is_nan(logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/dijkstra_min_select_if.sv
// Custom-instruction bus between the CPU and the min-select block.
//   start  : one-cycle command strobe
//   n      : command code (see dijkstra_pkg::cmd_e)
//   dataa  : PUSH candidate distance (IEEE-754 single)
//   datab  : PUSH bit31 visited flag, low bits node index
//   done   : one-cycle completion pulse
//   result : command result, zero outside of done
interface dijkstra_min_select_if;
   logic        start;
   logic [1:0]  n;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic        done;
   logic [31:0] result;

   modport master (output start, n, dataa, datab, input done, result);
   modport slave  (input start, n, dataa, datab, output done, result);
endinterface

// File: rtl/dijkstra_fp_less.sv
// Combinational a < b for single-precision distances.
//   a  : candidate; rejected (lt=0) when negative or NaN
//   b  : reference, assumed non-negative and not NaN
//   lt : 1 when a is an acceptable value strictly below b
// Non-negative floats order the same as their magnitude bits read unsigned.
module dijkstra_fp_less
   import dijkstra_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        lt
);

   assign lt = !a[31] && !fp_is_nan(a) && (a[30:0] < b[30:0]);

endmodule

// File: rtl/dijkstra_min_select.sv
// Running-minimum selector: tracks the smallest unvisited distance and its
// node index across PUSH commands; fixed 2-enabled-cycle command latency.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   clk_en  : clock enable, all state holds while low
//   bus     : custom-instruction command/result bus (slave side)
module dijkstra_min_select
   import dijkstra_pkg::*;
#(
   parameter int unsigned IDX_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clk_en,
   dijkstra_min_select_if.slave  bus
);

   typedef enum logic {S_IDLE, S_S1} state_e;

   state_e             state_q, state_d;
   cmd_e               cmd_q, cmd_d;
   logic [31:0]        cand_dist_q, cand_dist_d;
   logic               cand_vis_q, cand_vis_d;
   logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
   logic [31:0]        best_dist_q, best_dist_d;
   logic [IDX_W-1:0]   best_idx_q, best_idx_d;
   logic               found_q, found_d;
   logic               done_q, done_d;
   logic [31:0]        result_q, result_d;
   logic               cand_lt;

   dijkstra_fp_less u_less (
      .a  (cand_dist_q),
      .b  (best_dist_q),
      .lt (cand_lt)
   );

   // Next-state: everything holds unless clk_en is high.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cand_dist_d = cand_dist_q;
      cand_vis_d  = cand_vis_q;
      cand_idx_d  = cand_idx_q;
      best_dist_d = best_dist_q;
      best_idx_d  = best_idx_q;
      found_d     = found_q;
      done_d      = done_q;
      result_d    = result_q;

      if (clk_en) begin
         done_d   = 1'b0;
         result_d = 32'd0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d     = S_S1;
                  cmd_d       = cmd_e'(bus.n);
                  cand_dist_d = bus.dataa;
                  cand_vis_d  = bus.datab[31];
                  cand_idx_d  = bus.datab[IDX_W-1:0];
               end
            end
            S_S1: begin
               // A start seen here is dropped; the command completes now.
               state_d = S_IDLE;
               done_d  = 1'b1;
               unique case (cmd_q)
                  CMD_CLEAR: begin
                     best_dist_d = FP_POS_INF;
                     best_idx_d  = '1;
                     found_d     = 1'b0;
                  end
                  CMD_PUSH: begin
                     if (!cand_vis_q && cand_lt) begin
                        best_dist_d = cand_dist_q;
                        best_idx_d  = cand_idx_q;
                        found_d     = 1'b1;
                     end
                  end
                  CMD_READ_IDX:  result_d = found_q ? 32'(best_idx_q) : 32'hFFFF_FFFF;
                  CMD_READ_DIST: result_d = best_dist_q;
               endcase
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and pipeline registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cmd_q       <= CMD_CLEAR;
         cand_dist_q <= 32'd0;
         cand_vis_q  <= 1'b0;
         cand_idx_q  <= '0;
         best_dist_q <= FP_POS_INF;
         best_idx_q  <= '1;
         found_q     <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= 32'd0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cand_dist_q <= cand_dist_d;
         cand_vis_q  <= cand_vis_d;
         cand_idx_q  <= cand_idx_d;
         best_dist_q <= best_dist_d;
         best_idx_q  <= best_idx_d;
         found_q     <= found_d;
         done_q      <= done_d;
         result_q    <= result_d;
      end
   end

   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_dijkstra_min_select.sv
// Directed bench for dijkstra_min_select: reset defaults, selection, rejects,
// CLEAR, back-to-back issue, clk_en stall and reset mid-command.
module tb_dijkstra_min_select;
   import dijkstra_pkg::*;

   logic clk;
   logic reset_n;
   logic clk_en;
   int   checks;
   int   failures;

   logic [31:0] res;
   int          lat;
   logic        got;

   dijkstra_min_select_if bus ();

   dijkstra_min_select #(.IDX_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_en  (clk_en),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Issue one command starting 1 time unit after a posedge; returns at the
   // sample point of the done cycle (or after a bounded wait).
   task automatic do_cmd(input cmd_e c, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.n     = c;
      bus.dataa = a;
      bus.datab = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      got = bus.done;
      res = bus.result;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clk_en  = 1'b1;
      bus.start = 1'b0; bus.n = 2'd0; bus.dataa = 32'd0; bus.datab = 32'd0;
      #3;
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
      #9 reset_n = 1'b1;
      @(posedge clk); #1;
      do_cmd(CMD_READ_DIST, 32'd0, 32'd0);
      checks++; if (got !== 1'b1 || lat != 2) begin failures++; $display("FAIL reset_dist_latency got=%0d exp=2", lat); end
      checks++; if (res !== 32'h7F80_0000) begin failures++; $display("FAIL reset_dist got=%h exp=7f800000", res); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0 || bus.result !== 32'd0) begin failures++; $display("FAIL done_one_cycle got=%b/%h exp=0/0", bus.done, bus.result); end
      do_cmd(CMD_READ_IDX, 32'd0, 32'd0);
      checks++; if (got !== 1'b1 || lat != 2) begin failures++; $display("FAIL reset_idx_latency got=%0d exp=2", lat); end
      checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_idx got=%h exp=ffffffff", res); end
   endtask

   task automatic test_selection();
      do_cmd(CMD_CLEAR, 32'd0, 32'd0);
      do_cmd(CMD_PUSH, 32'h4040_0000, 32'd5);
      checks++; if (got !== 1'b1 || lat != 2 || res !== 32'd0) begin failures++; $display("FAIL push_latency got=%0d/%h exp=2/0", lat, res); end
      do_cmd(CMD_PUSH, 32'h3FC0_0000, 32'd9);
      do_cmd(CMD_PUSH, 32'h3FC0_0000, 32'd2);
      do_cmd(CMD_PUSH, 32'h4000_0000, 32'd1);
      do_cmd(CMD_READ_IDX, 32'd0, 32'd0);
      checks++; if (res !== 32'd9) begin failures++; $display("FAIL select_idx got=%h exp=9", res); end
      do_cmd(CMD_READ_DIST, 32'd0, 32'd0);
      checks++; if (res !== 32'h3FC0_0000) begin failures++; $display("FAIL select_dist got=%h exp=3fc00000", res); end
   endtask

   task automatic test_rejects();
      do_cmd(CMD_CLEAR, 32'd0, 32'd0);
      checks++; if (got !== 1'b1 || res !== 32'd0) begin failures++; $display("FAIL clear_done got=%b/%h exp=1/0", got, res); end
      do_cmd(CMD_PUSH, 32'h3F00_0000, 32'h8000_0003);
      do_cmd(CMD_PUSH, 32'hBF80_0000, 32'd1);
      do_cmd(CMD_PUSH, 32'h7FC0_0000, 32'd1);
      do_cmd(CMD_PUSH, 32'h7F80_0000, 32'd1);
      do_cmd(CMD_READ_IDX, 32'd0, 32'd0);
      checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reject_idx got=%h exp=ffffffff", res); end
      do_cmd(CMD_READ_DIST, 32'd0, 32'd0);
      checks++; if (res !== 32'h7F80_0000) begin failures++; $display("FAIL reject_dist got=%h exp=7f800000", res); end
   endtask

   task automatic test_clear();
      do_cmd(CMD_PUSH, 32'h3F80_0000, 32'd4);
      do_cmd(CMD_CLEAR, 32'd0, 32'd0);
      do_cmd(CMD_PUSH, 32'h4100_0000, 32'd7);
      do_cmd(CMD_READ_IDX, 32'd0, 32'd0);
      checks++; if (res !== 32'd7) begin failures++; $display("FAIL clear_idx got=%h exp=7", res); end
      do_cmd(CMD_READ_DIST, 32'd0, 32'd0);
      checks++; if (res !== 32'h4100_0000) begin failures++; $display("FAIL clear_dist got=%h exp=41000000", res); end
   endtask

   task automatic test_back_to_back();
      do_cmd(CMD_CLEAR, 32'd0, 32'd0);
      do_cmd(CMD_PUSH, 32'h3F80_0000, 32'd6);
      checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL b2b_on_done got=%b exp=1", bus.done); end
      // Issued in the done cycle of the PUSH.
      do_cmd(CMD_READ_IDX, 32'd0, 32'd0);
      checks++; if (got !== 1'b1 || lat != 2 || res !== 32'd6) begin failures++; $display("FAIL b2b_read got=%0d/%h exp=2/6", lat, res); end
      // Start held into S1 must be ignored.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.n = CMD_PUSH; bus.dataa = 32'h3F00_0000; bus.datab = 32'd11;
      @(posedge clk); #1;
      bus.dataa = 32'h3E80_0000; bus.datab = 32'd12;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL s1_first_done got=%b exp=1", bus.done); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL s1_ignored_done got=%b exp=0", bus.done); end
      do_cmd(CMD_READ_IDX, 32'd0, 32'd0);
      checks++; if (res !== 32'd11) begin failures++; $display("FAIL s1_ignored_idx got=%h exp=b", res); end
   endtask

   task automatic test_stall();
      do_cmd(CMD_PUSH, 32'h3E00_0000, 32'd13);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.n = CMD_READ_DIST;
      @(posedge clk); #1;
      bus.start = 1'b0;
      clk_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL stall_no_done cyc=%0d got=%b exp=0", i, bus.done); end
      end
      clk_en = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b1 || bus.result !== 32'h3E00_0000) begin failures++; $display("FAIL stall_done got=%b/%h exp=1/3e000000", bus.done, bus.result); end
      clk_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b1 || bus.result !== 32'h3E00_0000) begin failures++; $display("FAIL stall_hold got=%b/%h exp=1/3e000000", bus.done, bus.result); end
      clk_en = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", bus.done); end
      do_cmd(CMD_READ_IDX, 32'd0, 32'd0);
      checks++; if (res !== 32'd13) begin failures++; $display("FAIL stall_idx got=%h exp=d", res); end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.n = CMD_PUSH; bus.dataa = 32'h3E80_0000; bus.datab = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL reset_mid_done got=%0d exp=0", seen); end
      do_cmd(CMD_READ_DIST, 32'd0, 32'd0);
      checks++; if (got !== 1'b1 || res !== 32'h7F80_0000) begin failures++; $display("FAIL reset_mid_dist got=%h exp=7f800000", res); end
      do_cmd(CMD_READ_IDX, 32'd0, 32'd0);
      checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_mid_idx got=%h exp=ffffffff", res); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_selection();
      test_rejects();
      test_clear();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
